// File: rtl/cirno_ctrl.sv
// rtl/cirno_ctrl.sv - Cirno core sequencer: PC, instruction fetch, decode/exec/mem/wb stepping
module cirno_ctrl #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,

    // instruction memory port
    output logic            imem_req_o,
    input  logic            imem_ack_i,
    input  logic [8:0]      imem_rdata_i,

    // decoder interface
    output logic [8:0]      inst_o,
    output logic            decoder_en_o,
    input  logic [2:0]      inst_type_i,
    input  logic            branch_i,
    input  logic            branchi_i,
    input  logic            done_i,
    input  logic [5:0]      immediate_i,
    input  logic [PC_W-1:0] rx_data_i,

    // execute / memory / write-back strobes
    output logic            alu_en_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    input  logic            dmem_ack_i,
    output logic            reg_wr_en_o,

    // status
    output logic [PC_W-1:0] pc_o,
    output logic [15:0]     instret_o,
    output logic            halted_o,
    output logic            fault_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [2:0] T_ALU   = 3'd1;
    localparam logic [2:0] T_BRI   = 3'd2;
    localparam logic [2:0] T_BRR   = 3'd3;
    localparam logic [2:0] T_MOVE  = 3'd4;
    localparam logic [2:0] T_STORE = 3'd5;
    localparam logic [2:0] T_LOAD  = 3'd6;

    // Wait counter must be able to hold TIMEOUT itself.
    localparam int             CW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  WAIT_MAX = CW'(TIMEOUT);

    logic [2:0]      state_q,   state_d;
    logic [PC_W-1:0] pc_q,      pc_d;
    logic [15:0]     instret_q, instret_d;
    logic [8:0]      inst_q,    inst_d;
    logic [2:0]      type_q,    type_d;
    logic [CW-1:0]   wait_q,    wait_d;
    logic            fault_q,   fault_d;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_rel;
    logic [PC_W-1:0] imm_sext;
    logic [15:0]     instret_inc;

    // Arithmetic helpers; all wrap naturally at their register widths.
    always_comb begin
        imm_sext    = PC_W'($signed(immediate_i));
        pc_inc      = pc_q + PC_W'(1);
        pc_rel      = pc_q + imm_sext;
        instret_inc = instret_q + 16'd1;
    end

    // Next-state logic for the sequencer, PC, retire counter and ack-wait counter.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        inst_d    = inst_q;
        type_d    = type_q;
        wait_d    = wait_q;
        fault_d   = fault_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end

            S_FETCH: begin
                // An ack on the last allowed wait cycle still completes the fetch.
                if (imem_ack_i) begin
                    inst_d  = imem_rdata_i;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_MAX) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end

            S_DECODE: begin
                state_d = S_EXEC;
            end

            S_EXEC: begin
                // Remember the type so MEM/WB do not depend on the decoder holding it.
                type_d = inst_type_i;
                if (done_i && (inst_type_i == T_BRI)) begin
                    instret_d = instret_inc;
                    state_d   = S_HALT;
                end else begin
                    case (inst_type_i)
                        T_ALU, T_MOVE: begin
                            state_d = S_WB;
                        end
                        T_STORE, T_LOAD: begin
                            state_d = S_MEM;
                            wait_d  = '0;
                        end
                        T_BRI: begin
                            pc_d      = branchi_i ? pc_rel : pc_inc;
                            instret_d = instret_inc;
                            state_d   = S_FETCH;
                            wait_d    = '0;
                        end
                        T_BRR: begin
                            pc_d      = branch_i ? rx_data_i : pc_inc;
                            instret_d = instret_inc;
                            state_d   = S_FETCH;
                            wait_d    = '0;
                        end
                        default: begin
                            // Types 0 and 7 behave as a nop.
                            pc_d      = pc_inc;
                            instret_d = instret_inc;
                            state_d   = S_FETCH;
                            wait_d    = '0;
                        end
                    endcase
                end
            end

            S_MEM: begin
                if (dmem_ack_i) begin
                    if (type_q == T_STORE) begin
                        pc_d      = pc_inc;
                        instret_d = instret_inc;
                        state_d   = S_FETCH;
                        wait_d    = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_MAX) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end

            S_WB: begin
                pc_d      = pc_inc;
                instret_d = instret_inc;
                state_d   = S_FETCH;
                wait_d    = '0;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset is asynchronous so requests drop without waiting for a clock.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            inst_q    <= '0;
            type_q    <= '0;
            wait_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            inst_q    <= inst_d;
            type_q    <= type_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
        end
    end

    // Strobes and requests are decoded from the current state only (plus the live type in EXEC).
    always_comb begin
        imem_req_o   = (state_q == S_FETCH);
        decoder_en_o = (state_q == S_DECODE);
        alu_en_o     = (state_q == S_EXEC) && (inst_type_i == T_ALU);
        dmem_req_o   = (state_q == S_MEM);
        dmem_we_o    = (state_q == S_MEM) && (type_q == T_STORE);
        reg_wr_en_o  = (state_q == S_WB);
        halted_o     = (state_q == S_HALT);
        fault_o      = fault_q;
        inst_o       = inst_q;
        pc_o         = pc_q;
        instret_o    = instret_q;
    end

endmodule

// File: tb/tb_cirno_ctrl.sv
// tb/tb_cirno_ctrl.sv - scoreboard bench for cirno_ctrl
module tb_cirno_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        imem_req_o;
    logic        imem_ack_i = 1'b0;
    logic [8:0]  imem_rdata_i = '0;
    logic [8:0]  inst_o;
    logic        decoder_en_o;
    logic [2:0]  inst_type_i = '0;
    logic        branch_i = 1'b0;
    logic        branchi_i = 1'b0;
    logic        done_i = 1'b0;
    logic [5:0]  immediate_i = '0;
    logic [7:0]  rx_data_i = '0;
    logic        alu_en_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        dmem_ack_i = 1'b0;
    logic        reg_wr_en_o;
    logic [7:0]  pc_o;
    logic [15:0] instret_o;
    logic        halted_o;
    logic        fault_o;

    always #5 clk_i = ~clk_i;

    cirno_ctrl dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .imem_req_o   (imem_req_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .decoder_en_o (decoder_en_o),
        .inst_type_i  (inst_type_i),
        .branch_i     (branch_i),
        .branchi_i    (branchi_i),
        .done_i       (done_i),
        .immediate_i  (immediate_i),
        .rx_data_i    (rx_data_i),
        .alu_en_o     (alu_en_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_ack_i   (dmem_ack_i),
        .reg_wr_en_o  (reg_wr_en_o),
        .pc_o         (pc_o),
        .instret_o    (instret_o),
        .halted_o     (halted_o),
        .fault_o      (fault_o)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instret;
        logic        halted;
        logic        fault;
        logic [8:0]  inst;
        int          dec;
        int          alu;
        int          dm;
        int          we;
        int          wr;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] pc, input logic [15:0] ir, input logic h,
                                input logic f, input logic [8:0] inst, input int dec,
                                input int alu, input int dm, input int we, input int wr,
                                input int cyc);
        exp_t e;
        e.pc = pc; e.instret = ir; e.halted = h; e.fault = f; e.inst = inst;
        e.dec = dec; e.alu = alu; e.dm = dm; e.we = we; e.wr = wr; e.cyc = cyc;
        return e;
    endfunction

    // Monitor: an instruction ends when pc/instret/halted change; pop and compare its record.
    initial begin : monitor
        logic [24:0] prev;
        exp_t e;
        bit active;
        int dec, alu, dm, we, wr, cyc;
        prev = '0; active = 0;
        dec = 0; alu = 0; dm = 0; we = 0; wr = 0; cyc = 0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                active = 0;
                dec = 0; alu = 0; dm = 0; we = 0; wr = 0; cyc = 0;
                prev = {pc_o, instret_o, halted_o};
            end else begin
                if (active && ({pc_o, instret_o, halted_o} != prev)) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: pc=%0h instret=%0d expected none", pc_o, instret_o);
                    end else begin
                        e = expq.pop_front();
                        chk("pc", pc_o, e.pc);
                        chk("instret", instret_o, e.instret);
                        chk("halted", halted_o, e.halted);
                        chk("fault", fault_o, e.fault);
                        chk("inst", inst_o, e.inst);
                        chk("decoder_en_cycles", dec, e.dec);
                        chk("alu_en_cycles", alu, e.alu);
                        chk("dmem_req_cycles", dm, e.dm);
                        chk("dmem_we_cycles", we, e.we);
                        chk("reg_wr_en_cycles", wr, e.wr);
                        chk("latency", cyc, e.cyc);
                    end
                    active = 0;
                    dec = 0; alu = 0; dm = 0; we = 0; wr = 0; cyc = 0;
                end
                prev = {pc_o, instret_o, halted_o};
                if (imem_req_o) active = 1;
                if (active) begin
                    cyc++;
                    dec += int'(decoder_en_o);
                    alu += int'(alu_en_o);
                    dm  += int'(dmem_req_o);
                    we  += int'(dmem_we_o);
                    wr  += int'(reg_wr_en_o);
                end
            end
        end
    end

    task automatic run_inst(input logic [8:0] word, input logic [2:0] ty, input logic br,
                            input logic bri, input logic dn, input logic [5:0] imm,
                            input logic [7:0] rx, input int idly, input int ddly, input exp_t e);
        int n;
        expq.push_back(e);
        inst_type_i = ty; branch_i = br; branchi_i = bri; done_i = dn;
        immediate_i = imm; rx_data_i = rx;
        n = 0;
        while (!imem_req_o && n < 40) begin @(negedge clk_i); n++; end
        chk("fetch_req_seen", imem_req_o, 1);
        repeat (idly) @(negedge clk_i);
        imem_ack_i = 1'b1; imem_rdata_i = word;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        if (ty == 3'd5 || ty == 3'd6) begin
            n = 0;
            while (!dmem_req_o && n < 40) begin @(negedge clk_i); n++; end
            chk("mem_req_seen", dmem_req_o, 1);
            repeat (ddly) @(negedge clk_i);
            dmem_ack_i = 1'b1;
            @(negedge clk_i);
            dmem_ack_i = 1'b0;
        end
        n = 0;
        while (!imem_req_o && !halted_o && n < 40) begin @(negedge clk_i); n++; end
        chk("inst_end_seen", imem_req_o | halted_o, 1);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2 reset_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n;
        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_imem_req", imem_req_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_instret", instret_o, 0);
        chk("rst_halted", halted_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_inst", inst_o, 0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("idle_no_req", imem_req_o, 0);

        pulse_start();
        run_inst(9'h056, 3'd1, 0, 0, 0, 6'h00, 8'h00, 0, 0, mk(8'h01, 16'd1, 0, 0, 9'h056, 1, 1, 0, 0, 1, 4));
        run_inst(9'h101, 3'd2, 0, 0, 0, 6'h00, 8'h00, 0, 0, mk(8'h02, 16'd2, 0, 0, 9'h101, 1, 0, 0, 0, 0, 3));
        run_inst(9'h102, 3'd0, 0, 0, 0, 6'h00, 8'h00, 0, 0, mk(8'h03, 16'd3, 0, 0, 9'h102, 1, 0, 0, 0, 0, 3));
        run_inst(9'h103, 3'd7, 0, 0, 0, 6'h00, 8'h00, 0, 0, mk(8'h04, 16'd4, 0, 0, 9'h103, 1, 0, 0, 0, 0, 3));
        run_inst(9'h104, 3'd3, 0, 0, 0, 6'h00, 8'h77, 0, 0, mk(8'h05, 16'd5, 0, 0, 9'h104, 1, 0, 0, 0, 0, 3));
        run_inst(9'h105, 3'd2, 0, 1, 0, 6'h3E, 8'h00, 0, 0, mk(8'h03, 16'd6, 0, 0, 9'h105, 1, 0, 0, 0, 0, 3));
        run_inst(9'h106, 3'd3, 1, 0, 0, 6'h00, 8'hF0, 0, 0, mk(8'hF0, 16'd7, 0, 0, 9'h106, 1, 0, 0, 0, 0, 3));
        run_inst(9'h107, 3'd2, 0, 1, 0, 6'h1F, 8'h00, 0, 0, mk(8'h0F, 16'd8, 0, 0, 9'h107, 1, 0, 0, 0, 0, 3));
        run_inst(9'h108, 3'd3, 1, 0, 0, 6'h00, 8'hA4, 0, 0, mk(8'hA4, 16'd9, 0, 0, 9'h108, 1, 0, 0, 0, 0, 3));
        run_inst(9'h109, 3'd6, 0, 0, 0, 6'h00, 8'h00, 0, 3, mk(8'hA5, 16'd10, 0, 0, 9'h109, 1, 0, 4, 0, 1, 8));
        run_inst(9'h10A, 3'd5, 0, 0, 0, 6'h00, 8'h00, 0, 0, mk(8'hA6, 16'd11, 0, 0, 9'h10A, 1, 0, 1, 1, 0, 4));
        run_inst(9'h10B, 3'd1, 0, 0, 0, 6'h00, 8'h00, 2, 0, mk(8'hA7, 16'd12, 0, 0, 9'h10B, 1, 1, 0, 0, 1, 6));
        run_inst(9'h10C, 3'd2, 0, 0, 0, 6'h00, 8'h00, 15, 0, mk(8'hA8, 16'd13, 0, 0, 9'h10C, 1, 0, 0, 0, 0, 18));
        run_inst(9'h10D, 3'd4, 0, 0, 0, 6'h00, 8'h00, 0, 0, mk(8'hA9, 16'd14, 0, 0, 9'h10D, 1, 0, 0, 0, 1, 4));
        run_inst(9'h10E, 3'd2, 0, 1, 1, 6'h05, 8'h00, 0, 0, mk(8'hA9, 16'd15, 1, 0, 9'h10E, 1, 0, 0, 0, 0, 3));
        done_i = 1'b0; branchi_i = 1'b0;

        // HALT ignores start
        start_i = 1'b1;
        repeat (3) @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        chk("halt_sticky", halted_o, 1);
        chk("halt_no_fetch", imem_req_o, 0);
        chk("halt_pc", pc_o, 8'hA9);

        // Fetch timeout
        do_reset();
        chk("rst2_halted", halted_o, 0);
        chk("rst2_instret", instret_o, 0);
        expq.push_back(mk(8'h00, 16'd0, 1, 1, 9'h000, 0, 0, 0, 0, 0, 16));
        pulse_start();
        n = 0;
        while (!halted_o && n < 60) begin @(negedge clk_i); n++; end
        chk("timeout_halted", halted_o, 1);
        chk("timeout_req_dropped", imem_req_o, 0);
        chk("timeout_fault", fault_o, 1);

        // Asynchronous reset in the middle of a data access
        do_reset();
        pulse_start();
        run_inst(9'h111, 3'd2, 0, 0, 0, 6'h00, 8'h00, 0, 0, mk(8'h01, 16'd1, 0, 0, 9'h111, 1, 0, 0, 0, 0, 3));
        inst_type_i = 3'd6;
        imem_ack_i = 1'b1; imem_rdata_i = 9'h112;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        n = 0;
        while (!dmem_req_o && n < 40) begin @(negedge clk_i); n++; end
        chk("abort_mem_req_seen", dmem_req_o, 1);
        @(negedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        chk("abort_dmem_req", dmem_req_o, 0);
        chk("abort_reg_wr", reg_wr_en_o, 0);
        chk("abort_pc", pc_o, 0);
        chk("abort_instret", instret_o, 0);
        chk("abort_inst", inst_o, 0);
        chk("abort_halted", halted_o, 0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("abort_idle", imem_req_o, 0);
        chk("queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
